hazard_ctrl: RTL and testbench

Pipeline hazard controller that generates the `pause` (hold) and `nop` (squash) controls consumed by the PC/fetch stage of the 5-stage RV32I core (IF/ID/EX/MEM/WB). It resolves data hazards by stalling, with no forwarding. It keeps a shift-register scoreboard of destination registers still in flight, compares it against the sources of the instruction in ID, and runs a flush counter after a taken branch or jump. Saturating performance counters for stall and flush events are exposed for debug.

---
 rtl/hazard_ctrl.sv | 255 +++++++++++++++++++++++++
 tb/tb_hazard_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/squash controller for the 5-stage RV32I pipeline.
// A shift-register scoreboard tracks destination registers still in flight.
// The instruction in ID is held (pause) while any of its source registers
// matches a pending write. A small flush FSM keeps the fetch register
// squashed (nop) for a fixed number of cycles after a taken branch or jump.
// Saturating counters record stall cycles and accepted branch events.

// Protocol checker: flush must override stall, and a taken branch must squash.
module hazard_ctrl_chk (
  input logic i_clk,
  input logic i_rst_n,
  input logic i_branch_taken,
  input logic i_pause,
  input logic i_nop
);

  // A wrong-path instruction must never be held.
  a_no_pause_during_nop : assert property (@(posedge i_clk) disable iff (!i_rst_n)
    !(i_pause && i_nop));

  // The branch cycle itself is always squashed.
  a_branch_squashes : assert property (@(posedge i_clk) disable iff (!i_rst_n)
    i_branch_taken |-> i_nop);

endmodule

module hazard_ctrl #(
  parameter int DEPTH        = 3,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_instr_id,
  input  logic        i_branch_taken,
  output logic        o_pause,
  output logic        o_nop,
  output logic [15:0] o_stall_count,
  output logic [15:0] o_flush_count
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  // A single-cycle flush never leaves RUN; longer flushes preload the
  // remaining cycle count minus the one spent in the branch cycle itself.
  localparam logic       FLUSH_MULTI = (FLUSH_CYCLES > 1) ? 1'b1 : 1'b0;
  localparam logic [2:0] FCNT_RELOAD = (FLUSH_CYCLES > 1) ? 3'(FLUSH_CYCLES - 2) : 3'd0;

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  // Opcode uses rs1 unless it is one of the immediate-only forms.
  function automatic logic f_uses_rs1(input logic [6:0] op);
    logic res;
    case (op)
      OP_LUI, OP_AUIPC, OP_JAL: res = 1'b0;
      default:                  res = 1'b1;
    endcase
    return res;
  endfunction

  // Only R-type, stores and branches read rs2.
  function automatic logic f_uses_rs2(input logic [6:0] op);
    logic res;
    case (op)
      OP_REG, OP_STORE, OP_BRANCH: res = 1'b1;
      default:                     res = 1'b0;
    endcase
    return res;
  endfunction

  // Opcodes that write back to rd.
  function automatic logic f_writes_rd(input logic [6:0] op);
    logic res;
    case (op)
      OP_REG, OP_IMM, OP_LOAD, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: res = 1'b1;
      default:                                                    res = 1'b0;
    endcase
    return res;
  endfunction

  // Registered state
  logic [DEPTH-1:0] r_sb_valid;
  logic [4:0]       r_sb_rd [DEPTH];
  state_t           r_state;
  logic [2:0]       r_fcnt;
  logic [15:0]      r_stall_count;
  logic [15:0]      r_flush_count;

  // Combinational signals
  logic [6:0] w_opcode;
  logic [4:0] w_rs1;
  logic [4:0] w_rs2;
  logic [4:0] w_rd;
  logic       w_use_rs1;
  logic       w_use_rs2;
  logic       w_write_rd;
  logic       w_hazard;
  logic       w_nop;
  logic       w_pause;
  logic       w_entry_valid;
  logic [4:0] w_entry_rd;
  state_t     w_state_nxt;
  logic [2:0] w_fcnt_nxt;
  logic       w_unused_bits;

  assign w_opcode   = i_instr_id[6:0];
  assign w_rd       = i_instr_id[11:7];
  assign w_rs1      = i_instr_id[19:15];
  assign w_rs2      = i_instr_id[24:20];
  assign w_use_rs1  = f_uses_rs1(w_opcode);
  assign w_use_rs2  = f_uses_rs2(w_opcode);
  assign w_write_rd = f_writes_rd(w_opcode);

  // funct3/funct7 play no part in hazard detection.
  assign w_unused_bits = ^{i_instr_id[31:25], i_instr_id[14:12]};

  // Compare the used sources of the ID instruction against every pending write.
  always_comb begin
    w_hazard = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_sb_valid[i] &&
          ((w_use_rs1 && (w_rs1 != 5'd0) && (w_rs1 == r_sb_rd[i])) ||
           (w_use_rs2 && (w_rs2 != 5'd0) && (w_rs2 == r_sb_rd[i])))) begin
        w_hazard = 1'b1;
      end else begin
        w_hazard = w_hazard;
      end
    end
  end

  // Squash wins over hold so that a wrong-path instruction never stalls.
  always_comb begin
    w_nop   = i_branch_taken | (r_state == ST_FLUSH);
    w_pause = w_hazard & ~w_nop;
  end

  // Select what enters the EX slot: the ID instruction's write, or a bubble.
  always_comb begin
    w_entry_valid = 1'b0;
    w_entry_rd    = 5'd0;
    if (!w_pause && !w_nop) begin
      w_entry_valid = w_write_rd & (w_rd != 5'd0);
      w_entry_rd    = w_rd;
    end else begin
      w_entry_valid = 1'b0;
      w_entry_rd    = 5'd0;
    end
  end

  // Scoreboard shift register: entry 0 is EX, entry DEPTH-1 is WB.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_sb_valid <= {DEPTH{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        r_sb_rd[i] <= 5'd0;
      end
    end else begin
      r_sb_valid[0] <= w_entry_valid;
      r_sb_rd[0]    <= w_entry_rd;
      for (int i = 1; i < DEPTH; i++) begin
        r_sb_valid[i] <= r_sb_valid[i-1];
        r_sb_rd[i]    <= r_sb_rd[i-1];
      end
    end
  end

  // Flush FSM next-state: a branch (re)loads the counter, otherwise count down.
  always_comb begin
    w_state_nxt = r_state;
    w_fcnt_nxt  = r_fcnt;
    case (r_state)
      ST_RUN: begin
        if (i_branch_taken && FLUSH_MULTI) begin
          w_state_nxt = ST_FLUSH;
          w_fcnt_nxt  = FCNT_RELOAD;
        end else begin
          w_state_nxt = ST_RUN;
          w_fcnt_nxt  = r_fcnt;
        end
      end
      ST_FLUSH: begin
        if (i_branch_taken) begin
          w_state_nxt = ST_FLUSH;
          w_fcnt_nxt  = FCNT_RELOAD;
        end else if (r_fcnt == 3'd0) begin
          w_state_nxt = ST_RUN;
          w_fcnt_nxt  = 3'd0;
        end else begin
          w_state_nxt = ST_FLUSH;
          w_fcnt_nxt  = r_fcnt - 3'd1;
        end
      end
      default: begin
        w_state_nxt = ST_RUN;
        w_fcnt_nxt  = 3'd0;
      end
    endcase
  end

  // Flush FSM state register.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state <= ST_RUN;
      r_fcnt  <= 3'd0;
    end else begin
      r_state <= w_state_nxt;
      r_fcnt  <= w_fcnt_nxt;
    end
  end

  // Saturating debug counters for stall cycles and accepted branches.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_stall_count <= 16'd0;
      r_flush_count <= 16'd0;
    end else begin
      if (w_pause && (r_stall_count != CNT_MAX)) begin
        r_stall_count <= r_stall_count + 16'd1;
      end else begin
        r_stall_count <= r_stall_count;
      end
      if (i_branch_taken && (r_flush_count != CNT_MAX)) begin
        r_flush_count <= r_flush_count + 16'd1;
      end else begin
        r_flush_count <= r_flush_count;
      end
    end
  end

  assign o_pause       = w_pause;
  assign o_nop         = w_nop;
  assign o_stall_count = r_stall_count;
  assign o_flush_count = r_flush_count;

  hazard_ctrl_chk u_chk (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst),
    .i_branch_taken (i_branch_taken),
    .i_pause        (w_pause),
    .i_nop          (w_nop)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with hand-computed expectations.
module tb_hazard_ctrl;

  localparam logic [31:0] NOP        = 32'h00000013; // addi x0,x0,0
  localparam logic [31:0] ADDI_X5    = 32'h00100293; // addi x5,x0,1
  localparam logic [31:0] ADD_X6     = 32'h00528333; // add  x6,x5,x5
  localparam logic [31:0] ADDI_X8    = 32'h00200413; // addi x8,x0,2
  localparam logic [31:0] LUI_X7     = 32'h000283B7; // lui  x7,0x28 (bits 19:15 = 5)
  localparam logic [31:0] ADDI_X0    = 32'h00100013; // addi x0,x0,1
  localparam logic [31:0] ADD_X6_X0  = 32'h00000333; // add  x6,x0,x0
  localparam logic [31:0] SW_X5      = 32'h0054A023; // sw   x5,0(x9)
  localparam logic [31:0] ADD_X7_X6  = 32'h006303B3; // add  x7,x6,x6
  localparam logic [31:0] ADD_X5_X5  = 32'h005282B3; // add  x5,x5,x5

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic        bt;
  logic        pause;
  logic        nop;
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;

  logic        sat_rst;
  logic [31:0] sat_instr;
  logic        sat_bt;
  logic        sat_pause;
  logic        sat_nop;
  logic [15:0] sat_stall;
  logic [15:0] sat_flush;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.DEPTH(3), .FLUSH_CYCLES(2)) u_dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_instr_id     (instr),
    .i_branch_taken (bt),
    .o_pause        (pause),
    .o_nop          (nop),
    .o_stall_count  (stall_cnt),
    .o_flush_count  (flush_cnt)
  );

  // Deep scoreboard instance: a self-dependent instruction stalls 32 of every
  // 33 cycles, reaching counter saturation quickly.
  hazard_ctrl #(.DEPTH(32), .FLUSH_CYCLES(2)) u_sat (
    .i_clk          (clk),
    .i_rst          (sat_rst),
    .i_instr_id     (sat_instr),
    .i_branch_taken (sat_bt),
    .o_pause        (sat_pause),
    .o_nop          (sat_nop),
    .o_stall_count  (sat_stall),
    .o_flush_count  (sat_flush)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [31:0] ins, input logic b);
    instr = ins;
    bt    = b;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    drive(NOP, 1'b0);
    repeat (3) tick();
  endtask

  initial begin
    rst       = 1'b0;
    sat_rst   = 1'b0;
    instr     = NOP;
    bt        = 1'b0;
    sat_instr = ADD_X5_X5;
    sat_bt    = 1'b0;

    // Reset state
    repeat (2) tick();
    chk("rst_pause", {31'd0, pause}, 32'd0);
    chk("rst_nop",   {31'd0, nop},   32'd0);
    chk("rst_stall", {16'd0, stall_cnt}, 32'd0);
    chk("rst_flush", {16'd0, flush_cnt}, 32'd0);
    rst     = 1'b1;
    sat_rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(NOP, 1'b0);
      chk("nop_stream_pause", {31'd0, pause}, 32'd0);
      chk("nop_stream_nop",   {31'd0, nop},   32'd0);
      tick();
    end

    // Back-to-back RAW: 3 stall cycles
    drive(ADDI_X5, 1'b0);
    chk("b2b_producer_pause", {31'd0, pause}, 32'd0);
    tick();
    drive(ADD_X6, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk("b2b_pause_hi", {31'd0, pause}, 32'd1);
      tick();
    end
    chk("b2b_pause_lo", {31'd0, pause}, 32'd0);
    chk("b2b_stall_cnt", {16'd0, stall_cnt}, 32'd3);
    tick();
    drain();

    // One independent instruction between: 2 stall cycles
    drive(ADDI_X5, 1'b0);
    tick();
    drive(ADDI_X8, 1'b0);
    chk("dist1_indep_pause", {31'd0, pause}, 32'd0);
    tick();
    drive(ADD_X6, 1'b0);
    chk("dist1_pause_hi0", {31'd0, pause}, 32'd1);
    tick();
    chk("dist1_pause_hi1", {31'd0, pause}, 32'd1);
    tick();
    chk("dist1_pause_lo", {31'd0, pause}, 32'd0);
    chk("dist1_stall_cnt", {16'd0, stall_cnt}, 32'd5);
    tick();
    drain();

    // LUI ignores its rs1 field
    drive(ADDI_X5, 1'b0);
    tick();
    drive(LUI_X7, 1'b0);
    chk("lui_no_pause", {31'd0, pause}, 32'd0);
    tick();
    drain();

    // x0 is never recorded and never matches
    drive(ADDI_X0, 1'b0);
    tick();
    drive(ADD_X6_X0, 1'b0);
    chk("x0_no_pause", {31'd0, pause}, 32'd0);
    tick();
    drain();

    // Store depends through rs2 only
    drive(ADDI_X5, 1'b0);
    tick();
    drive(SW_X5, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk("sw_rs2_pause_hi", {31'd0, pause}, 32'd1);
      tick();
    end
    chk("sw_rs2_pause_lo", {31'd0, pause}, 32'd0);
    chk("sw_stall_cnt", {16'd0, stall_cnt}, 32'd8);
    tick();
    drain();

    // Taken branch with a conflicting instruction in ID
    drive(ADDI_X5, 1'b0);
    tick();
    drive(ADD_X6, 1'b1);
    chk("br_c0_nop",   {31'd0, nop},   32'd1);
    chk("br_c0_pause", {31'd0, pause}, 32'd0);
    tick();
    drive(ADD_X6, 1'b0);
    chk("br_c1_nop",   {31'd0, nop},   32'd1);
    chk("br_c1_pause", {31'd0, pause}, 32'd0);
    tick();
    drive(ADD_X7_X6, 1'b0);
    chk("br_c2_nop",   {31'd0, nop},   32'd0);
    chk("br_bubbles_no_x6", {31'd0, pause}, 32'd0);
    chk("br_flush_cnt", {16'd0, flush_cnt}, 32'd1);
    chk("br_stall_cnt", {16'd0, stall_cnt}, 32'd8);
    tick();
    drain();

    // Second branch on the 2nd squash cycle extends nop to 3 cycles
    drive(NOP, 1'b1);
    chk("brf_c0_nop", {31'd0, nop}, 32'd1);
    tick();
    drive(NOP, 1'b1);
    chk("brf_c1_nop", {31'd0, nop}, 32'd1);
    tick();
    drive(NOP, 1'b0);
    chk("brf_c2_nop", {31'd0, nop}, 32'd1);
    tick();
    chk("brf_c3_nop", {31'd0, nop}, 32'd0);
    chk("brf_flush_cnt", {16'd0, flush_cnt}, 32'd3);
    drain();

    // Reset asserted in the middle of a stall
    drive(ADDI_X5, 1'b0);
    tick();
    drive(ADD_X6, 1'b0);
    chk("mrst_pre_pause", {31'd0, pause}, 32'd1);
    rst = 1'b0;
    #1;
    chk("mrst_pause_async", {31'd0, pause}, 32'd0);
    chk("mrst_stall_cnt",   {16'd0, stall_cnt}, 32'd0);
    chk("mrst_flush_cnt",   {16'd0, flush_cnt}, 32'd0);
    #1;
    rst = 1'b1;
    #1;
    chk("mrst_post_pause", {31'd0, pause}, 32'd0);
    tick();
    chk("mrst_post_pause2", {31'd0, pause}, 32'd0);
    chk("mrst_post_stall",  {16'd0, stall_cnt}, 32'd0);
    drain();

    // Saturation of the stall counter (>= 65540 stall cycles elapsed)
    repeat (68000) tick();
    chk("sat_stall_cnt", {16'd0, sat_stall}, 32'h0000FFFF);
    chk("sat_flush_cnt", {16'd0, sat_flush}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
